// File: rtl/beat_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : beat_bcd_if
// Purpose  : Bundles the raw heartbeat input with the BCD result, strobe and
//            status flags of the beat counter. The master side is the counter
//            itself; the slave side is the sensor/display environment.
// Revision : 1.0 - initial release
// ============================================================================
interface beat_bcd_if;
    logic       beat_in;      // raw asynchronous sensor pulse
    logic [7:0] value;        // packed BCD: tens [7:4], units [3:0]
    logic       value_valid;  // one-cycle strobe when value updates
    logic       busy;         // conversion in progress
    logic       ovf;          // last window count exceeded 99

    modport master (
        input  beat_in,
        output value,
        output value_valid,
        output busy,
        output ovf
    );

    modport slave (
        output beat_in,
        input  value,
        input  value_valid,
        input  busy,
        input  ovf
    );
endinterface
`default_nettype wire

// File: rtl/beat_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : beat_bcd_counter
// Purpose  : Counts debounced heartbeat edges over a fixed window of clk
//            cycles and presents the count as two-digit packed BCD (clamped
//            to 99 with an overflow flag). Binary-to-BCD conversion is a
//            sequential double-dabble, one shift per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module beat_bcd_counter #(
    parameter int GATE_CYCLES    = 50_000_000,  // window length, >= 16
    parameter int HOLDOFF_CYCLES = 2_500_000    // dead time after a beat, >= 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    beat_bcd_if.master      bus
);

    localparam int             c_win_w   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int             c_hold_w  = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [c_win_w-1:0]  c_win_last = c_win_w'(GATE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_ld  = c_hold_w'(HOLDOFF_CYCLES);
    localparam logic [7:0]     c_bcd_max = 8'd99;
    localparam logic [7:0]     c_cnt_sat = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync2_q;
    logic [c_hold_w-1:0]  r_holdoff;
    logic [c_win_w-1:0]   r_win_cnt;
    logic [7:0]           r_beat_cnt;

    state_t               r_state;
    logic [15:0]          r_shift;      // {bcd[7:0], bin[7:0]}
    logic [2:0]           r_shift_cnt;
    logic                 r_ovf_pend;

    logic [7:0]           r_value;
    logic                 r_value_valid;
    logic                 r_busy;
    logic                 r_ovf;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_win_end;
    logic [7:0]           w_cnt_inc;
    logic [7:0]           w_snap;
    logic                 w_over;
    logic [7:0]           w_clamped;
    logic [3:0]           w_tens_adj;
    logic [3:0]           w_units_adj;
    logic [15:0]          w_shift_next;

    assign w_rise    = r_sync2 & ~r_sync2_q;
    assign w_accept  = w_rise && (r_holdoff == '0);
    assign w_win_end = (r_win_cnt == c_win_last);

    // Saturating increment: the counter sticks at 255 instead of wrapping.
    assign w_cnt_inc = (r_beat_cnt == c_cnt_sat) ? c_cnt_sat : (r_beat_cnt + 8'd1);

    // A beat accepted on the window-end cycle belongs to the closing window.
    assign w_snap    = w_accept ? w_cnt_inc : r_beat_cnt;
    assign w_over    = (w_snap > c_bcd_max);
    assign w_clamped = w_over ? c_bcd_max : w_snap;

    // Double-dabble step: add 3 to any BCD digit >= 5, then shift left.
    // Input never exceeds 99, so two BCD digits never carry out.
    assign w_tens_adj   = (r_shift[15:12] >= 4'd5) ? (r_shift[15:12] + 4'd3) : r_shift[15:12];
    assign w_units_adj  = (r_shift[11:8]  >= 4'd5) ? (r_shift[11:8]  + 4'd3) : r_shift[11:8];
    assign w_shift_next = {w_tens_adj, w_units_adj, r_shift[7:0]} << 1;

    // Two-flop synchroniser for the asynchronous beat input plus edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_q <= 1'b0;
        end else begin
            r_sync1   <= bus.beat_in;
            r_sync2   <= r_sync1;
            r_sync2_q <= r_sync2;
        end
    end

    // Holdoff timer: reload on an accepted beat, then count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdoff <= '0;
        end else if (w_accept) begin
            r_holdoff <= c_hold_ld;
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - 1'b1;
        end
    end

    // Window counter: free-running 0..GATE_CYCLES-1, wraps at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    // Beat counter: saturating, cleared at window end after being snapshotted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= 8'h00;
        end else if (w_win_end) begin
            r_beat_cnt <= 8'h00;
        end else if (w_accept) begin
            r_beat_cnt <= w_cnt_inc;
        end
    end

    // Conversion FSM: capture at window end, 8 dabble shifts, then publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_shift       <= 16'h0000;
            r_shift_cnt   <= 3'd0;
            r_ovf_pend    <= 1'b0;
            r_value       <= 8'h00;
            r_value_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_end) begin
                        r_shift     <= {8'h00, w_clamped};
                        r_ovf_pend  <= w_over;
                        r_shift_cnt <= 3'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift     <= w_shift_next;
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                    if (r_shift_cnt == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_value       <= r_shift[15:8];
                    r_ovf         <= r_ovf_pend;
                    r_value_valid <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.busy        = r_busy;
    assign bus.ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_beat_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_beat_bcd_counter
// Purpose  : Directed self-checking bench for beat_bcd_counter. Two instances:
//            a short-window one (100 cycles) for timing, bounce, edge and
//            reset cases, and a 1000-cycle one for overflow clamping.
//            Index k counts falling clock edges after reset release; the
//            window ending at k=99 (mod window) publishes at k=109.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beat_bcd_counter;

    localparam int GATE_A = 100;
    localparam int HOLD_A = 4;
    localparam int GATE_B = 1000;
    localparam int HOLD_B = 4;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    beat_bcd_if bus_a ();
    beat_bcd_if bus_b ();

    beat_bcd_counter #(.GATE_CYCLES(GATE_A), .HOLDOFF_CYCLES(HOLD_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.master)
    );

    beat_bcd_counter #(.GATE_CYCLES(GATE_B), .HOLDOFF_CYCLES(HOLD_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit sched_a [0:1023];
    bit sched_b [0:2047];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step falling edges k0..k1: sample outputs, then drive beat_in from schedule.
    task automatic run(input int sel, input int k0, input int k1,
                       output int vcnt, output int vidx, output int bcnt,
                       output logic [7:0] v, output logic o);
        vcnt = 0; vidx = -1; bcnt = 0; v = 8'h00; o = 1'b0;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            if (sel == 0) begin
                if (bus_a.value_valid) begin
                    vcnt++;
                    if (vidx < 0) begin vidx = k; v = bus_a.value; o = bus_a.ovf; end
                end
                if (bus_a.busy) bcnt++;
                bus_a.beat_in = sched_a[k];
            end else begin
                if (bus_b.value_valid) begin
                    vcnt++;
                    if (vidx < 0) begin vidx = k; v = bus_b.value; o = bus_b.ovf; end
                end
                if (bus_b.busy) bcnt++;
                bus_b.beat_in = sched_b[k];
            end
        end
    endtask

    int         vc, vi, bc, rv;
    logic [7:0] v;
    logic       o;

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.beat_in = 1'b0;
        bus_b.beat_in = 1'b0;
        for (int i = 0; i < 1024; i++) sched_a[i] = 1'b0;
        for (int i = 0; i < 2048; i++) sched_b[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_value", {24'h0, bus_a.value}, 32'h00);
        chk("rst_valid", {31'h0, bus_a.value_valid}, 32'h0);
        chk("rst_busy",  {31'h0, bus_a.busy}, 32'h0);
        chk("rst_ovf",   {31'h0, bus_a.ovf}, 32'h0);

        @(negedge clk);
        rst_n_a = 1'b1;

        // Window 1: 12 clean pulses, 6 cycles apart
        for (int i = 0; i < 12; i++) sched_a[5 + 6 * i] = 1'b1;
        run(0, 1, 110, vc, vi, bc, v, o);
        chk("clean_vcnt", vc, 1);
        chk("clean_vidx", vi, 109);
        chk("clean_busy", bc, 9);
        chk("clean_value", {24'h0, v}, 32'h12);
        chk("clean_ovf", {31'h0, o}, 32'h0);

        // Window 2: three edges 2 cycles apart count once
        sched_a[120] = 1'b1; sched_a[122] = 1'b1; sched_a[124] = 1'b1;
        run(0, 111, 209, vc, vi, bc, v, o);
        chk("bounce_vcnt", vc, 1);
        chk("bounce_vidx", vi, 209);
        chk("bounce_value", {24'h0, v}, 32'h01);

        // Window 3: empty still converts and strobes
        run(0, 210, 309, vc, vi, bc, v, o);
        chk("empty_vcnt", vc, 1);
        chk("empty_vidx", vi, 309);
        chk("empty_value", {24'h0, v}, 32'h00);

        // Window 4: last beat reaches edge detect exactly on window end (k=399)
        sched_a[330] = 1'b1; sched_a[340] = 1'b1; sched_a[397] = 1'b1;
        run(0, 310, 409, vc, vi, bc, v, o);
        chk("edge_vidx", vi, 409);
        chk("edge_value", {24'h0, v}, 32'h03);

        // Window 5: two beats; would read 3 if the window-end beat spilled over
        sched_a[420] = 1'b1; sched_a[430] = 1'b1;
        run(0, 410, 509, vc, vi, bc, v, o);
        chk("next_value", {24'h0, v}, 32'h02);
        chk("next_vidx", vi, 509);

        // Window 6: beats, then reset during the conversion
        sched_a[520] = 1'b1; sched_a[530] = 1'b1; sched_a[540] = 1'b1;
        run(0, 510, 603, vc, vi, bc, v, o);
        chk("pre_rst_vcnt", vc, 0);
        chk("pre_rst_busy", {31'h0, bus_a.busy}, 32'h1);
        rst_n_a = 1'b0;
        bus_a.beat_in = 1'b1;
        #1;
        chk("async_value", {24'h0, bus_a.value}, 32'h00);
        chk("async_valid", {31'h0, bus_a.value_valid}, 32'h0);
        chk("async_busy",  {31'h0, bus_a.busy}, 32'h0);
        chk("async_ovf",   {31'h0, bus_a.ovf}, 32'h0);
        rv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_a.value_valid || bus_a.busy) rv++;
        end
        chk("in_rst_quiet", rv, 0);

        // Release with beat_in already high: counts as one edge, plus 4 more
        for (int i = 0; i < 1024; i++) sched_a[i] = 1'b0;
        sched_a[1] = 1'b1; sched_a[2] = 1'b1;
        sched_a[10] = 1'b1; sched_a[20] = 1'b1; sched_a[30] = 1'b1; sched_a[40] = 1'b1;
        rst_n_a = 1'b1;
        run(0, 1, 110, vc, vi, bc, v, o);
        chk("post_rst_vcnt", vc, 1);
        chk("post_rst_vidx", vi, 109);
        chk("post_rst_value", {24'h0, v}, 32'h05);

        // Overflow instance: 120 beats clamp to 99, next window with 5 beats
        for (int i = 0; i < 120; i++) sched_b[5 + 8 * i] = 1'b1;
        for (int i = 0; i < 5; i++)   sched_b[1100 + 8 * i] = 1'b1;
        @(negedge clk);
        rst_n_b = 1'b1;
        run(1, 1, 1009, vc, vi, bc, v, o);
        chk("ovf_vcnt", vc, 1);
        chk("ovf_vidx", vi, 1009);
        chk("ovf_value", {24'h0, v}, 32'h99);
        chk("ovf_flag", {31'h0, o}, 32'h1);
        run(1, 1010, 1500, vc, vi, bc, v, o);
        chk("hold_vcnt", vc, 0);
        chk("hold_value", {24'h0, bus_b.value}, 32'h99);
        chk("hold_ovf", {31'h0, bus_b.ovf}, 32'h1);
        run(1, 1501, 2010, vc, vi, bc, v, o);
        chk("ovf2_vidx", vi, 2009);
        chk("ovf2_value", {24'h0, v}, 32'h05);
        chk("ovf2_flag", {31'h0, o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
